// File: rtl/spram_be_clr.sv
// spram_be_clr: single-port RAM with byte enables, selectable read-during-write, optional output register and post-reset clear.
// Define SPRAM_PARITY_EN to store one even-parity bit per byte lane and flag mismatches on read.
module spram_be_clr #(
   parameter int data_width = 8,
   parameter int addr_width = 10,
   parameter int RDW_MODE   = 0,
   parameter int OUT_REG    = 0,
   parameter int CLEAR_EN   = 1
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    cs,
   input  logic                    wren,
   input  logic [data_width/8-1:0] byteen,
   input  logic [addr_width-1:0]   address,
   input  logic [data_width-1:0]   data,
   output logic [data_width-1:0]   q,
   output logic                    valid,
   output logic                    busy,
   output logic                    parity_err
);
   localparam int NB = data_width / 8;
`ifdef SPRAM_PARITY_EN
   localparam int PW = NB;
`else
   localparam int PW = 0;
`endif
   localparam int W     = data_width + PW;
   localparam int DEPTH = 2 ** addr_width;
   typedef enum logic {CLEAR, READY} state_t;
   state_t state, state_nx;
   logic [addr_width-1:0] clr_addr;
   logic [W-1:0] mem [DEPTH];
   logic [W-1:0] old_w, new_w, rd_w;
   logic [data_width-1:0] q1;
   logic acc, err, v1, e1;
   assign acc   = state == READY && cs;
   assign busy  = state == CLEAR;
   assign old_w = mem[address];
   assign rd_w  = RDW_MODE != 0 ? old_w : new_w;
   // Merged word: enabled lanes (and their parity) from data, the rest from the array.
   always_comb begin
      new_w = old_w;
      for (int i = 0; i < NB; i++)
         if (wren && byteen[i]) begin
            new_w[8*i+:8] = data[8*i+:8];
`ifdef SPRAM_PARITY_EN
            new_w[data_width+i] = ^data[8*i+:8];
`endif
         end
   end
   always_comb begin
      err = 1'b0;
`ifdef SPRAM_PARITY_EN
      for (int i = 0; i < NB; i++)
         err = err | ((^rd_w[8*i+:8]) != rd_w[data_width+i]);
`endif
   end
   always_comb begin
      state_nx = state;
      if (state == CLEAR && clr_addr == '1) state_nx = READY;
   end
   always_ff @(posedge clock or negedge reset_n)
      if (!reset_n) begin
         state    <= CLEAR_EN != 0 ? CLEAR : READY;
         clr_addr <= '0;
         q1       <= '0;
         v1       <= 1'b0;
         e1       <= 1'b0;
      end else begin
         state <= state_nx;
         if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
         v1 <= acc;
         e1 <= acc && err;
         if (acc) q1 <= rd_w[data_width-1:0];
      end
   // Array itself is not reset; the clear sequencer zeroes it instead.
   always_ff @(posedge clock)
      if (state == CLEAR) mem[clr_addr] <= '0;
      else if (acc && wren) mem[address] <= new_w;
   generate
      if (OUT_REG != 0) begin : g_oreg
         logic [data_width-1:0] q2;
         logic v2, e2;
         always_ff @(posedge clock or negedge reset_n)
            if (!reset_n) begin
               q2 <= '0;
               v2 <= 1'b0;
               e2 <= 1'b0;
            end else begin
               v2 <= v1;
               e2 <= e1;
               if (v1) q2 <= q1;
            end
         assign q          = q2;
         assign valid      = v2;
         assign parity_err = e2;
      end else begin : g_direct
         assign q          = q1;
         assign valid      = v1;
         assign parity_err = e1;
      end
   endgenerate
endmodule

// File: tb/tb_spram_be_clr.sv
// tb_spram_be_clr: two instances (write-first/latency 1 and read-first/latency 2) checked against a bench memory model.
module tb_spram_be_clr;
   logic clock, reset_n, cs, wren;
   logic [1:0] byteen;
   logic [3:0] address;
   logic [15:0] data, q0, q1;
   logic valid0, valid1, busy0, busy1, perr0, perr1;
   int checks, errors, clr_left, flip_addr;
   logic [15:0] m [16];
   logic [15:0] last0, last1;
   typedef struct {logic v; logic [15:0] q; logic pe;} exp_t;
   exp_t sb0[$], sb1[$];
   typedef struct {logic c; logic w; logic [1:0] be; logic [3:0] a; logic [15:0] d; logic [15:0] x0; logic [15:0] x1;} vec_t;
   vec_t vt [13];

   spram_be_clr #(.data_width(16), .addr_width(4), .RDW_MODE(0), .OUT_REG(0), .CLEAR_EN(1)) u0 (
      .clock(clock), .reset_n(reset_n), .cs(cs), .wren(wren), .byteen(byteen), .address(address),
      .data(data), .q(q0), .valid(valid0), .busy(busy0), .parity_err(perr0));
   spram_be_clr #(.data_width(16), .addr_width(4), .RDW_MODE(1), .OUT_REG(1), .CLEAR_EN(1)) u1 (
      .clock(clock), .reset_n(reset_n), .cs(cs), .wren(wren), .byteen(byteen), .address(address),
      .data(data), .q(q1), .valid(valid1), .busy(busy1), .parity_err(perr1));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic step(input logic c, input logic w, input logic [1:0] be, input logic [3:0] a,
                       input logic [15:0] d, input bit he = 0, input logic [15:0] x0 = 0, input logic [15:0] x1 = 0);
      logic acc;
      logic [15:0] old, mrg;
      exp_t e;
      cs = c; wren = w; byteen = be; address = a; data = d;
      acc = c && clr_left == 0;
      old = m[a];
      mrg = old;
      if (w) for (int i = 0; i < 2; i++) if (be[i]) mrg[8*i+:8] = d[8*i+:8];
      if (acc) begin
         last0 = he ? x0 : mrg;
         last1 = he ? x1 : old;
         if (w) m[a] = mrg;
      end
      e.v = acc; e.q = last0; e.pe = acc && int'(a) == flip_addr;
      sb0.push_back(e);
      e.q = last1; e.pe = 1'b0;
      sb1.push_back(e);
      @(posedge clock);
      if (clr_left > 0) clr_left--;
      @(negedge clock);
      e = sb0.pop_front();
      chk("q0", q0, e.q);
      chk("valid0", valid0, e.v);
      chk("perr0", perr0, e.pe);
      if (sb1.size() > 1) begin
         e = sb1.pop_front();
         chk("q1", q1, e.q);
         chk("valid1", valid1, e.v);
         chk("perr1", perr1, e.pe);
      end
      chk("busy0", busy0, clr_left > 0);
      chk("busy1", busy1, clr_left > 0);
   endtask

   task automatic do_reset();
      exp_t e;
      @(negedge clock);
      reset_n = 1'b0; cs = 1'b0; wren = 1'b0;
      #1;
      chk("rst_q0", q0, 0);
      chk("rst_q1", q1, 0);
      chk("rst_valid0", valid0, 0);
      chk("rst_valid1", valid1, 0);
      chk("rst_busy0", busy0, 1);
      @(negedge clock);
      foreach (m[i]) m[i] = '0;
      clr_left = 16; last0 = '0; last1 = '0;
      sb0.delete(); sb1.delete();
      e.v = 1'b0; e.q = '0; e.pe = 1'b0;
      sb1.push_back(e);
      reset_n = 1'b1;
   endtask

   initial begin
      checks = 0; errors = 0; flip_addr = -1;
      reset_n = 1'b0; cs = 1'b0; wren = 1'b0; byteen = '0; address = '0; data = '0;
      vt[0]  = '{1, 1, 2'b11, 4'd3, 16'hA55A, 16'hA55A, 16'h0000};
      vt[1]  = '{1, 1, 2'b01, 4'd3, 16'h00FF, 16'hA5FF, 16'hA55A};
      vt[2]  = '{1, 0, 2'b00, 4'd3, 16'h0000, 16'hA5FF, 16'hA5FF};
      vt[3]  = '{1, 1, 2'b11, 4'd0, 16'h0011, 16'h0011, 16'h0000};
      vt[4]  = '{1, 1, 2'b11, 4'd1, 16'h0022, 16'h0022, 16'h0000};
      vt[5]  = '{1, 1, 2'b11, 4'd2, 16'h0033, 16'h0033, 16'h0000};
      vt[6]  = '{1, 0, 2'b00, 4'd0, 16'h0000, 16'h0011, 16'h0011};
      vt[7]  = '{1, 0, 2'b00, 4'd1, 16'h0000, 16'h0022, 16'h0022};
      vt[8]  = '{1, 0, 2'b00, 4'd2, 16'h0000, 16'h0033, 16'h0033};
      vt[9]  = '{1, 1, 2'b00, 4'd1, 16'hFFFF, 16'h0022, 16'h0022};
      vt[10] = '{1, 0, 2'b00, 4'd1, 16'h0000, 16'h0022, 16'h0022};
      vt[11] = '{1, 1, 2'b10, 4'd2, 16'h7700, 16'h7733, 16'h0033};
      vt[12] = '{1, 0, 2'b00, 4'd2, 16'h0000, 16'h7733, 16'h7733};
      do_reset();
      // Writes during clear must be ignored; then every address reads zero.
      repeat (16) step(1, 1, 2'b11, 4'd3, 16'hFFFF);
      for (int a = 0; a < 16; a++) step(1, 0, 2'b00, 4'(a), 16'h0);
      step(0, 0, 2'b00, 4'd0, 16'h0);
      foreach (vt[i]) step(vt[i].c, vt[i].w, vt[i].be, vt[i].a, vt[i].d, 1, vt[i].x0, vt[i].x1);
      step(0, 1, 2'b11, 4'd2, 16'hDEAD);
      step(1, 0, 2'b00, 4'd2, 16'h0);
      repeat (80) step(1'($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom), 4'($urandom), 16'($urandom));
      // Reset in the middle of a clear restarts the full sequence.
      do_reset();
      repeat (7) step(0, 0, 2'b00, 4'd0, 16'h0);
      do_reset();
      repeat (16) step(0, 0, 2'b00, 4'd0, 16'h0);
      for (int a = 0; a < 16; a++) step(1, 0, 2'b00, 4'(a), 16'h0);
`ifdef SPRAM_PARITY_EN
      step(1, 1, 2'b11, 4'd5, 16'h1234);
      step(1, 1, 2'b11, 4'd6, 16'h5678);
      u0.mem[5][0] = ~u0.mem[5][0];
      flip_addr = 5;
      step(1, 0, 2'b00, 4'd5, 16'h0, 1, 16'h1235, 16'h1234);
      step(1, 0, 2'b00, 4'd6, 16'h0);
      step(0, 0, 2'b00, 4'd0, 16'h0);
`endif
      step(0, 0, 2'b00, 4'd0, 16'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
